// File: rtl/invaders_pkg.sv
// Shared types and default geometry for the alien fleet game logic.
package invaders_pkg;

  typedef enum logic [2:0] {WAIT, SCAN, MOVE, CLEARED, LANDED} fleet_state_t;
  typedef enum logic {RIGHT, LEFT} dir_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 8;
  localparam int DEF_CELL_W = 64;
  localparam int DEF_CELL_H = 48;

  // Index width that stays legal for a count of one.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared by the VGA pipeline (1024x768 @ 65 MHz).
package vga_pkg;

  localparam int HOR_PIXELS = 1024;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned box intersection test; all sums carried in 13 bits.
module rect_overlap #(
  parameter int A_W = 48,
  parameter int A_H = 32,
  parameter int B_W = 16,
  parameter int B_H = 32
) (
  input  logic [12:0] ax,
  input  logic [12:0] ay,
  input  logic [12:0] bx,
  input  logic [12:0] by,
  output logic        hit
);

  assign hit = (bx < ax + 13'(A_W)) && (ax < bx + 13'(B_W)) &&
               (by < ay + 13'(A_H)) && (ay < by + 13'(B_H));

endmodule

// File: rtl/invader_fleet_ctl.sv
// Per-frame alien formation controller: scans for one projectile kill, then steps the fleet.
// Optional build macro INVADER_SPEEDUP_EN shortens the step period as aliens die.
module invader_fleet_ctl
  import invaders_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int CELL_W      = DEF_CELL_W,
  parameter int CELL_H      = DEF_CELL_H,
  parameter int ALIEN_W     = 48,
  parameter int ALIEN_H     = 32,
  parameter int BULLET_W    = 16,
  parameter int BULLET_H    = 32,
  parameter int START_X     = 64,
  parameter int START_Y     = 32,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 16,
  parameter int STEP_PERIOD = 30,
  parameter int LAND_Y      = 704
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync,
  input  logic                 bullet_active,
  input  logic [11:0]          bullet_x,
  input  logic [11:0]          bullet_y,
  output logic                 bullet_hit,
  output logic [11:0]          fleet_xpos,
  output logic [11:0]          fleet_ypos,
  output logic [ROWS*COLS-1:0] alive,
  output logic [15:0]          score,
  output logic                 fleet_cleared,
  output logic                 fleet_landed
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = width_for(N);
  localparam int ROW_W = width_for(ROWS);
  localparam int COL_W = width_for(COLS);
  localparam int FC_W  = $clog2(STEP_PERIOD + 1);

  fleet_state_t     state_q, state_d;
  dir_t             dir_q, dir_d;
  logic             vsync_q;
  logic             tick;
  logic [11:0]      xpos_q, xpos_d, ypos_q, ypos_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [15:0]      score_q, score_d;
  logic             hit_q, hit_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [FC_W-1:0]  period_m1;
  logic             bact_q, bact_d;
  logic [11:0]      bx_q, bx_d, by_q, by_d;
  logic [IDX_W-1:0] idx_q, idx_d, kill_idx_q, kill_idx_d;
  logic [ROW_W-1:0] row_q, row_d, max_row_q, max_row_d;
  logic [COL_W-1:0] col_q, col_d, min_col_q, min_col_d, max_col_q, max_col_d;
  logic             kill_q, kill_d;
  logic [12:0]      cell_x, cell_y;
  logic             overlap, kill_now, cell_live;
  logic [12:0]      right_reach, left_reach, bottom_reach;

  assign tick   = vsync & ~vsync_q;
  assign cell_x = {1'b0, xpos_q} + 13'(col_q * CELL_W);
  assign cell_y = {1'b0, ypos_q} + 13'(row_q * CELL_H);

  rect_overlap #(
    .A_W (ALIEN_W),
    .A_H (ALIEN_H),
    .B_W (BULLET_W),
    .B_H (BULLET_H)
  ) u_overlap (
    .ax  (cell_x),
    .ay  (cell_y),
    .bx  ({1'b0, bx_q}),
    .by  ({1'b0, by_q}),
    .hit (overlap)
  );

  // Only the first live overlapping cell dies; extent tracking sees the post-kill mask.
  assign kill_now  = (state_q == SCAN) && bact_q && !kill_q && alive_q[idx_q] && overlap;
  assign cell_live = alive_q[idx_q] && !kill_now;

`ifdef INVADER_SPEEDUP_EN
  localparam int CNT_W = $clog2(N + 1);
  logic [CNT_W-1:0] alive_cnt_q, alive_cnt_d;
  int               kills;

  always_comb begin
    kills       = N - int'(alive_cnt_q);
    alive_cnt_d = alive_cnt_q;
    if (state_q == MOVE && kill_q) alive_cnt_d = alive_cnt_q - CNT_W'(1);
    if (kills >= STEP_PERIOD - 1) period_m1 = '0;
    else                          period_m1 = FC_W'(STEP_PERIOD - 1 - kills);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alive_cnt_q <= CNT_W'(N);
    else     alive_cnt_q <= alive_cnt_d;
  end
`else
  assign period_m1 = FC_W'(STEP_PERIOD - 1);
`endif

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    alive_d      = alive_q;
    score_d      = score_q;
    hit_d        = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    bact_d       = bact_q;
    bx_d         = bx_q;
    by_d         = by_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    kill_d       = kill_q;
    kill_idx_d   = kill_idx_q;
    min_col_d    = min_col_q;
    max_col_d    = max_col_q;
    max_row_d    = max_row_q;
    right_reach  = {1'b0, xpos_q} + 13'(max_col_q * CELL_W) + 13'(ALIEN_W + STEP_X);
    left_reach   = {1'b0, xpos_q} + 13'(min_col_q * CELL_W);
    bottom_reach = '0;

    case (state_q)
      WAIT: begin
        if (tick) begin
          bact_d     = bullet_active;
          bx_d       = bullet_x;
          by_d       = bullet_y;
          idx_d      = '0;
          row_d      = '0;
          col_d      = '0;
          kill_d     = 1'b0;
          kill_idx_d = '0;
          min_col_d  = COL_W'(COLS - 1);
          max_col_d  = '0;
          max_row_d  = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (kill_now) begin
          kill_d     = 1'b1;
          kill_idx_d = idx_q;
        end
        if (cell_live) begin
          if (col_q < min_col_q) min_col_d = col_q;
          if (col_q > max_col_q) max_col_d = col_q;
          if (row_q > max_row_q) max_row_d = row_q;
        end
        if (idx_q == IDX_W'(N - 1)) begin
          state_d = MOVE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == COL_W'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      MOVE: begin
        if (kill_q) begin
          alive_d[kill_idx_q] = 1'b0;
          hit_d               = 1'b1;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end
        if (alive_d == '0) begin
          state_d = CLEARED;
        end else begin
          state_d = WAIT;
          if (frame_cnt_q >= period_m1) begin
            frame_cnt_d = '0;
            if (dir_q == RIGHT) begin
              if (right_reach > 13'(vga_pkg::HOR_PIXELS)) begin
                ypos_d = ypos_q + 12'(STEP_Y);
                dir_d  = LEFT;
              end else begin
                xpos_d = xpos_q + 12'(STEP_X);
              end
            end else begin
              if (left_reach < 13'(STEP_X)) begin
                ypos_d = ypos_q + 12'(STEP_Y);
                dir_d  = RIGHT;
              end else begin
                xpos_d = xpos_q - 12'(STEP_X);
              end
            end
            bottom_reach = {1'b0, ypos_d} + 13'(max_row_q * CELL_H) + 13'(ALIEN_H);
            if (bottom_reach >= 13'(LAND_Y)) state_d = LANDED;
          end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT;
      dir_q       <= RIGHT;
      vsync_q     <= 1'b0;
      xpos_q      <= 12'(START_X);
      ypos_q      <= 12'(START_Y);
      alive_q     <= '1;
      score_q     <= '0;
      hit_q       <= 1'b0;
      frame_cnt_q <= '0;
      bact_q      <= 1'b0;
      bx_q        <= '0;
      by_q        <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      kill_q      <= 1'b0;
      kill_idx_q  <= '0;
      min_col_q   <= '0;
      max_col_q   <= '0;
      max_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      vsync_q     <= vsync;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      alive_q     <= alive_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      frame_cnt_q <= frame_cnt_d;
      bact_q      <= bact_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      kill_q      <= kill_d;
      kill_idx_q  <= kill_idx_d;
      min_col_q   <= min_col_d;
      max_col_q   <= max_col_d;
      max_row_q   <= max_row_d;
    end
  end

  assign bullet_hit    = hit_q;
  assign fleet_xpos    = xpos_q;
  assign fleet_ypos    = ypos_q;
  assign alive         = alive_q;
  assign score         = score_q;
  assign fleet_cleared = (state_q == CLEARED);
  assign fleet_landed  = (state_q == LANDED);

endmodule

// File: tb/tb_invader_fleet_ctl.sv
// Directed bench for invader_fleet_ctl with STEP_PERIOD=2; frames are 40 clocks long.
module tb_invader_fleet_ctl;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;
`ifdef INVADER_SPEEDUP_EN
  localparam int EXP_X_10KILLS = 136;
`else
  localparam int EXP_X_10KILLS = 104;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        bullet_active = 1'b0;
  logic [11:0] bullet_x = '0;
  logic [11:0] bullet_y = '0;
  logic        bullet_hit;
  logic [11:0] fleet_xpos, fleet_ypos;
  logic [31:0] alive;
  logic [15:0] score;
  logic        fleet_cleared, fleet_landed;

  int n_cmp = 0;
  int n_err = 0;
  int hit_cnt, hit_at, total_hits;
  int m_x, m_cnt, x_pre;

  always #5 clk = ~clk;

  invader_fleet_ctl #(.STEP_PERIOD(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .vsync         (vsync),
    .bullet_active (bullet_active),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_hit    (bullet_hit),
    .fleet_xpos    (fleet_xpos),
    .fleet_ypos    (fleet_ypos),
    .alive         (alive),
    .score         (score),
    .fleet_cleared (fleet_cleared),
    .fleet_landed  (fleet_landed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync = 1'b0;
    bullet_active = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1. The bullet inputs change after the tick to prove latching.
  task automatic do_frame(input logic act, input int x, input int y, input logic retick);
    bullet_active = act;
    bullet_x = 12'(x);
    bullet_y = 12'(y);
    vsync = 1'b1;
    hit_cnt = 0;
    hit_at = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        bullet_active = 1'b1;
        bullet_x = '0;
        bullet_y = '0;
      end
      if (n == 3) vsync = 1'b0;
      if (retick && n == 10) vsync = 1'b1;
      if (retick && n == 11) vsync = 1'b0;
      if (bullet_hit) begin
        hit_cnt++;
        if (hit_at < 0) hit_at = n;
      end
    end
    bullet_active = 1'b0;
  endtask

  // Expected step cadence while the fleet is moving right, away from the edge.
  task automatic model_step(input int kills_before);
    int period;
    period = 2;
`ifdef INVADER_SPEEDUP_EN
    period = (kills_before >= 1) ? 1 : 2 - kills_before;
`endif
    if (m_cnt >= period - 1) begin
      m_cnt = 0;
      m_x += 8;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    do_reset();
    check("rst_xpos", fleet_xpos, 64);
    check("rst_ypos", fleet_ypos, 32);
    check("rst_alive", alive, ALL1);
    check("rst_score", score, 0);
    check("rst_hit", bullet_hit, 0);
    check("rst_cleared", fleet_cleared, 0);
    check("rst_landed", fleet_landed, 0);

    total_hits = 0;
    do_frame(1'b0, 0, 0, 1'b0); total_hits += hit_cnt; check("idle_x1", fleet_xpos, 64);
    do_frame(1'b0, 0, 0, 1'b0); total_hits += hit_cnt; check("idle_x2", fleet_xpos, 72);
    do_frame(1'b0, 0, 0, 1'b0); total_hits += hit_cnt; check("idle_x3", fleet_xpos, 72);
    do_frame(1'b0, 0, 0, 1'b0); total_hits += hit_cnt; check("idle_x4", fleet_xpos, 80);
    check("idle_ypos", fleet_ypos, 32);
    check("idle_no_hit", total_hits, 0);

    do_reset();
    do_frame(1'b1, 64, 40, 1'b0);
    check("kill0_alive", alive, 32'hFFFF_FFFE);
    check("kill0_score", score, 1);
    check("kill0_pulses", hit_cnt, 1);
    check("kill0_latency", hit_at, 34);

    // Box straddles (0,0) and (1,0); only the lower index dies per frame.
    do_reset();
    do_frame(1'b1, 70, 56, 1'b0);
    check("dual_f1_alive", alive, 32'hFFFF_FFFE);
    do_frame(1'b1, 70, 56, 1'b1);
    check("dual_f2_alive", alive, 32'hFFFF_FEFE);
    check("dual_f2_pulses", hit_cnt, 1);
    check("dual_score", score, 2);
    check("dual_xpos", fleet_xpos, 72);

    // 58 steps bring xpos to 528, where the next step reverses.
    do_reset();
    for (int f = 0; f < 116; f++) do_frame(1'b0, 0, 0, 1'b0);
    check("edge_xpos", fleet_xpos, 528);
    check("edge_ypos", fleet_ypos, 32);
    do_frame(1'b0, 0, 0, 1'b0);
    do_frame(1'b0, 0, 0, 1'b0);
    check("rev_ypos", fleet_ypos, 48);
    check("rev_xpos", fleet_xpos, 528);
    do_frame(1'b0, 0, 0, 1'b0);
    do_frame(1'b0, 0, 0, 1'b0);
    check("left_xpos", fleet_xpos, 520);
    check("left_ypos", fleet_ypos, 48);

    // Kill every alien in index order, aiming inside each cell.
    do_reset();
    m_x = 64;
    m_cnt = 0;
    x_pre = 64;
    total_hits = 0;
    for (int i = 0; i < 32; i++) begin
      x_pre = m_x;
      do_frame(1'b1, m_x + (i % 8) * 64 + 10, 32 + (i / 8) * 48, 1'b0);
      total_hits += hit_cnt;
      if (i < 31) model_step(i);
      if (i == 9) check("ten_kill_xpos", fleet_xpos, EXP_X_10KILLS);
      if (i == 30) check("not_cleared_31", fleet_cleared, 0);
    end
    check("all_alive", alive, 0);
    check("all_score", score, 32);
    check("all_hits", total_hits, 32);
    check("all_cleared", fleet_cleared, 1);
    check("all_landed", fleet_landed, 0);
    check("all_xpos", fleet_xpos, x_pre);
    do_frame(1'b1, 64, 40, 1'b0);
    check("post_clear_hits", hit_cnt, 0);
    check("post_clear_score", score, 32);
    check("post_clear_xpos", fleet_xpos, x_pre);
    check("post_clear_flag", fleet_cleared, 1);

    // Asynchronous reset in the middle of a scan that already found a kill.
    do_reset();
    bullet_active = 1'b1;
    bullet_x = 12'd64;
    bullet_y = 12'd40;
    vsync = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_alive", alive, ALL1);
    check("midrst_score", score, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vsync = 1'b0;
    bullet_active = 1'b0;
    hit_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bullet_hit) hit_cnt++;
    end
    check("midrst_no_hit", hit_cnt, 0);
    check("midrst_alive_after", alive, ALL1);
    check("midrst_xpos", fleet_xpos, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
